riscv_rf_wb_arbiter: RTL and testbench



---
 rtl/riscv_rf_pkg.sv | 14 +
 rtl/riscv_rr_pick2.sv | 59 +++++
 rtl/riscv_rf_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_riscv_rf_wb_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_pkg.sv
// Shared register-file constants and the writeback request record.
// Used by the writeback arbiter and its round-robin picker.
package riscv_rf_pkg;

    localparam int RF_ADDR_WIDTH = 6;
    localparam int RF_DATA_WIDTH = 32;
    localparam logic [RF_ADDR_WIDTH-1:0] RF_X0_ADDR = '0;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } rf_wb_req_t;

endpackage

// File: rtl/riscv_rr_pick2.sv
// Combinational round-robin picker: the first request at or after ptr_i, then the
// next one that is not masked by conflict_i. Grants are one-hot, with index and valid.
module riscv_rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] conflict_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] first_oh_o,
    output logic               first_valid_o,
    output logic [PTR_W-1:0]   first_idx_o,
    output logic [NUM_REQ-1:0] second_oh_o,
    output logic               second_valid_o,
    output logic [PTR_W-1:0]   second_idx_o
);

    logic [NUM_REQ-1:0] second_cand;

    always_comb begin
        first_oh_o    = '0;
        first_valid_o = 1'b0;
        first_idx_o   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx_w;
            logic [PTR_W-1:0] idx;
            idx_w = int'(ptr_i) + i;
            if (idx_w >= NUM_REQ) idx_w = idx_w - NUM_REQ;
            idx = PTR_W'(idx_w);
            if (!first_valid_o && req_i[idx]) begin
                first_valid_o   = 1'b1;
                first_idx_o     = idx;
                first_oh_o[idx] = 1'b1;
            end
        end
    end

    // Kept in its own process: conflict_i is derived from first_oh_o outside.
    assign second_cand = req_i & ~first_oh_o & ~conflict_i;

    always_comb begin
        second_oh_o    = '0;
        second_valid_o = 1'b0;
        second_idx_o   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx_w;
            logic [PTR_W-1:0] idx;
            idx_w = int'(ptr_i) + i;
            if (idx_w >= NUM_REQ) idx_w = idx_w - NUM_REQ;
            idx = PTR_W'(idx_w);
            if (!second_valid_o && second_cand[idx]) begin
                second_valid_o   = 1'b1;
                second_idx_o     = idx;
                second_oh_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// Writeback arbiter for the dual-write-port register file: grants up to two
// non-x0 writes per cycle round-robin, absorbs x0 writes, registers the port outputs.
module riscv_rf_wb_arbiter
    import riscv_rf_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [ADDR_WIDTH-1:0]         waddr_a_o,
    output logic [DATA_WIDTH-1:0]         wdata_a_o,
    output logic                          we_a_o,
    output logic [ADDR_WIDTH-1:0]         waddr_b_o,
    output logic [DATA_WIDTH-1:0]         wdata_b_o,
    output logic                          we_b_o,
    output logic                          busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(RF_X0_ADDR);

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  we_a_q, we_a_d, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;

    logic [NUM_REQ-1:0]    x0_req, nz_req, conflict, grant;
    logic [NUM_REQ-1:0]    first_oh, second_oh;
    logic                  first_valid, second_valid;
    logic [PTR_W-1:0]      first_idx, second_idx;
    logic [ADDR_WIDTH-1:0] first_addr, second_addr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) return '0;
        return idx + PTR_W'(1);
    endfunction

    always_comb begin
        x0_req = '0;
        nz_req = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == X0) x0_req[k] = req_valid_i[k];
            else                                               nz_req[k] = req_valid_i[k];
        end
    end

    assign first_addr  = req_addr_i[first_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign second_addr = req_addr_i[second_idx*ADDR_WIDTH +: ADDR_WIDTH];

    // A second write to the port-A address must wait, so port B never aliases A.
    always_comb begin
        conflict = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            conflict[k] = (req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == first_addr);
        end
    end

    riscv_rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i          (nz_req),
        .conflict_i     (conflict),
        .ptr_i          (rr_ptr_q),
        .first_oh_o     (first_oh),
        .first_valid_o  (first_valid),
        .first_idx_o    (first_idx),
        .second_oh_o    (second_oh),
        .second_valid_o (second_valid),
        .second_idx_o   (second_idx)
    );

    assign grant       = x0_req | first_oh | second_oh;
    assign req_ready_o = rst_n ? grant : '0;
    assign busy_o      = rst_n & (|(req_valid_i & ~grant));

    always_comb begin
        we_a_d    = first_valid;
        waddr_a_d = waddr_a_q;
        wdata_a_d = wdata_a_q;
        we_b_d    = second_valid;
        waddr_b_d = waddr_b_q;
        wdata_b_d = wdata_b_q;
        rr_ptr_d  = rr_ptr_q;
        if (first_valid) begin
            waddr_a_d = first_addr;
            wdata_a_d = req_data_i[first_idx*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_d  = ptr_next(first_idx);
        end
        if (second_valid) begin
            waddr_b_d = second_addr;
            wdata_b_d = req_data_i[second_idx*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_d  = ptr_next(second_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            we_a_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            we_b_q    <= 1'b0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            we_a_q    <= we_a_d;
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            we_b_q    <= we_b_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
        end
    end

    assign we_a_o    = we_a_q;
    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wdata_a_q;
    assign we_b_o    = we_b_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wdata_b_q;

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Bench for riscv_rf_wb_arbiter: vector table of grant scenarios plus a reset
// sequence; registered writes are checked through an expected-write queue.
module tb_riscv_rf_wb_arbiter;
    import riscv_rf_pkg::*;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int SW = 2 * (1 + AW + DW);

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_ready_o;
    logic [AW-1:0]   waddr_a_o, waddr_b_o;
    logic [DW-1:0]   wdata_a_o, wdata_b_o;
    logic            we_a_o, we_b_o, busy_o;

    riscv_rf_wb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .waddr_a_o   (waddr_a_o),
        .wdata_a_o   (wdata_a_o),
        .we_a_o      (we_a_o),
        .waddr_b_o   (waddr_b_o),
        .wdata_b_o   (wdata_b_o),
        .we_b_o      (we_b_o),
        .busy_o      (busy_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    exp_ready;
        logic            exp_busy;
        int              a_idx;
        int              b_idx;
        logic [1:0]      exp_ptr;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];
    logic [SW-1:0] exp_q[$];
    logic [DW-1:0] cur_data[N];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                                input logic [N-1:0] r, input logic b, input int ai,
                                input int bi, input logic [1:0] p);
        vec_t t;
        t.valid = v; t.addr = a; t.exp_ready = r; t.exp_busy = b;
        t.a_idx = ai; t.b_idx = bi; t.exp_ptr = p;
        return t;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [N*AW-1:0] a, input int k);
        return a[k*AW +: AW];
    endfunction

    // Invariants on every registered write: no aliasing ports, never x0.
    always @(posedge clk) begin
        #1;
        if (rst_n && we_a_o && we_b_o) begin
            checks++;
            if (waddr_a_o == waddr_b_o) begin
                failures++;
                $display("FAIL port_alias actual=%0h expected=different", waddr_a_o);
            end
        end
        if (rst_n && (we_a_o || we_b_o)) begin
            checks++;
            if ((we_a_o && waddr_a_o == RF_X0_ADDR) || (we_b_o && waddr_b_o == RF_X0_ADDR)) begin
                failures++;
                $display("FAIL x0_written actual=0 expected=nonzero");
            end
        end
    end

    // driver: present one vector, check the handshake, queue the expected writes
    task automatic drive_vec(input int vi);
        vec_t t;
        logic [SW-1:0] e;
        t = vecs[vi];
        @(negedge clk);
        req_valid_i = t.valid;
        req_addr_i  = t.addr;
        for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = cur_data[k];
        #1;
        chk($sformatf("v%0d_ready", vi), 64'(req_ready_o), 64'(t.exp_ready));
        chk($sformatf("v%0d_busy", vi), 64'(busy_o), 64'(t.exp_busy));
        e = '0;
        if (t.a_idx >= 0) e[SW-1 -: (1+AW+DW)] = {1'b1, addr_of(t.addr, t.a_idx), cur_data[t.a_idx]};
        if (t.b_idx >= 0) e[(1+AW+DW)-1:0]     = {1'b1, addr_of(t.addr, t.b_idx), cur_data[t.b_idx]};
        exp_q.push_back(e);
        for (int k = 0; k < N; k++) if (t.exp_ready[k]) cur_data[k] = $urandom;
    endtask

    // scoreboard: compare the registered writes one cycle after the handshake
    task automatic check_out(input int vi);
        logic [SW-1:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d_we_a", vi), 64'(we_a_o), 64'(e[SW-1]));
        if (e[SW-1]) begin
            chk($sformatf("v%0d_waddr_a", vi), 64'(waddr_a_o), 64'(e[SW-2 -: AW]));
            chk($sformatf("v%0d_wdata_a", vi), 64'(wdata_a_o), 64'(e[SW-2-AW -: DW]));
        end
        chk($sformatf("v%0d_we_b", vi), 64'(we_b_o), 64'(e[AW+DW]));
        if (e[AW+DW]) begin
            chk($sformatf("v%0d_waddr_b", vi), 64'(waddr_b_o), 64'(e[AW+DW-1 -: AW]));
            chk($sformatf("v%0d_wdata_b", vi), 64'(wdata_b_o), 64'(e[DW-1:0]));
        end
        chk($sformatf("v%0d_rr_ptr", vi), 64'(dut.rr_ptr_q), 64'(vecs[vi].exp_ptr));
    endtask

    initial begin
        //                valid    addr {a3,a2,a1,a0}               ready    busy  A   B  ptr
        vecs[0]  = mk(4'b0001, {6'd0,  6'd0,  6'd0,  6'd5},  4'b0001, 1'b0, 0, -1, 2'd1);
        vecs[1]  = mk(4'b0110, {6'd0,  6'd7,  6'd3,  6'd0},  4'b0110, 1'b0, 1,  2, 2'd3);
        vecs[2]  = mk(4'b0011, {6'd0,  6'd0,  6'd9,  6'd9},  4'b0001, 1'b1, 0, -1, 2'd1);
        vecs[3]  = mk(4'b0010, {6'd0,  6'd0,  6'd9,  6'd0},  4'b0010, 1'b0, 1, -1, 2'd2);
        vecs[4]  = mk(4'b1101, {6'd33, 6'd0,  6'd0,  6'd4},  4'b1101, 1'b0, 3,  0, 2'd1);
        vecs[5]  = mk(4'b1000, {6'd12, 6'd0,  6'd0,  6'd0},  4'b1000, 1'b0, 3, -1, 2'd0);
        vecs[6]  = mk(4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 4'b0011, 1'b1, 0,  1, 2'd2);
        vecs[7]  = mk(4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 4'b1100, 1'b1, 2,  3, 2'd0);
        vecs[8]  = mk(4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 4'b0011, 1'b1, 0,  1, 2'd2);
        vecs[9]  = mk(4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 4'b1100, 1'b1, 2,  3, 2'd0);
        vecs[10] = mk(4'b0110, {6'd0,  6'd32, 6'd32, 6'd0},  4'b0010, 1'b1, 1, -1, 2'd2);
        vecs[11] = mk(4'b1100, {6'd0,  6'd32, 6'd0,  6'd0},  4'b1100, 1'b0, 2, -1, 2'd3);
        vecs[12] = mk(4'b0000, {6'd0,  6'd0,  6'd0,  6'd0},  4'b0000, 1'b0, -1, -1, 2'd3);
        vecs[13] = mk(4'b0001, {6'd0,  6'd0,  6'd0,  6'd0},  4'b0001, 1'b0, -1, -1, 2'd3);
        vecs[14] = mk(4'b1011, {6'd7,  6'd0,  6'd7,  6'd7},  4'b1000, 1'b1, 3, -1, 2'd0);
        for (int k = 0; k < N; k++) cur_data[k] = $urandom;
        cur_data[0] = 32'hDEADBEEF;

        // reset state, with requests already presented
        rst_n       = 1'b0;
        req_valid_i = 4'b1111;
        req_addr_i  = {6'd4, 6'd3, 6'd2, 6'd1};
        req_data_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_we_a", 64'(we_a_o), 64'd0);
        chk("rst_we_b", 64'(we_b_o), 64'd0);
        chk("rst_waddr_a", 64'(waddr_a_o), 64'd0);
        chk("rst_wdata_b", 64'(wdata_b_o), 64'd0);
        chk("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        @(negedge clk);
        req_valid_i = '0;
        rst_n = 1'b1;

        for (int vi = 0; vi < NV; vi++) begin
            drive_vec(vi);
            check_out(vi);
        end

        // reset one cycle after a dual grant
        @(negedge clk);
        req_valid_i = 4'b0110;
        req_addr_i  = {6'd0, 6'd21, 6'd20, 6'd0};
        @(posedge clk);
        #1;
        chk("mid_we_a_before", 64'(we_a_o), 64'd1);
        chk("mid_we_b_before", 64'(we_b_o), 64'd1);
        chk("mid_waddr_a_before", 64'(waddr_a_o), 64'd20);
        chk("mid_waddr_b_before", 64'(waddr_b_o), 64'd21);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_we_a_rst", 64'(we_a_o), 64'd0);
        chk("mid_we_b_rst", 64'(we_b_o), 64'd0);
        chk("mid_ready_rst", 64'(req_ready_o), 64'd0);
        chk("mid_busy_rst", 64'(busy_o), 64'd0);
        chk("mid_ptr_rst", 64'(dut.rr_ptr_q), 64'd0);
        @(negedge clk);
        req_valid_i = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_we_a", 64'(we_a_o), 64'd0);
        chk("post_rst_we_b", 64'(we_b_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
